conv_lif_core: RTL and testbench
================================

# conv_lif_core

Parametrised event-driven convolutional LIF neuron core: accumulates weighted pre-synaptic events into a membrane-potential BRAM for `EC_SIZE` local output channels. On command, it sweeps every neuron, adds bias, applies leak, thresholds and streams spikes. It sits between the layer's spike-event scheduler (upstream) and the next layer's spike buffer (downstream). Arithmetic is signed fixed point with saturation; a hazard-free read-modify-write pipeline allows back-to-back events.

## Interface
- `IN_CHANNELS`, 2, input channels.
- `EC_SIZE`, 2, local output channels per core.
- `KERNEL_SIZE`, 3, kernel side K.
- `OUT_WIDTH`, 26, output frame side; S = `OUT_WIDTH`².
- `POT_WIDTH`, 16, membrane word width (signed).
- `W_WIDTH`, 8, weight/bias width (signed).
- `THRESHOLD`, 256, firing threshold, POT_WIDTH signed.
- `BETA_SHIFT`, 3, leak shift; leak = v − (v >>> BETA_SHIFT).
- `MEM_AW`, $clog2(EC_SIZE·S), membrane address width.
- `W_AW`, $clog2(EC_SIZE·(IN_CHANNELS·K²+1)), weight address width.

Ports:
- `clk` in 1 — clock.
- `rst` in 1 — synchronous, active-high reset.
- `ev_valid` / `ev_ready` in/out 1 — event handshake; an event transfers when both are high.
- `ev_y`, `ev_x` in $clog2(OUT_WIDTH) — affected output neuron.
- `ev_oc` in $clog2(EC_SIZE) — local output channel.
- `ev_kidx` in $clog2(IN_CHANNELS·K²) — ic·K² + filter phase.
- `ev_skip` in 1 — event is consumed without update.
- `act_start` in 1 — one-cycle activation command.
- `last_time_step` in 1 — sampled at `act_start`.
- `busy` out 1; `act_done` out 1 — busy flag; one-cycle pulse at end of activation.
- `spk_valid`, `spk`, `spk_addr`[MEM_AW] out — spike stream, one neuron per cycle, no backpressure.
- `w_addr`[W_AW], `w_ren` out; `w_rdata`[W_WIDTH] in — weight ROM, 1-cycle read latency.
- `mem_raddr`[MEM_AW], `mem_ren` out; `mem_rdata`[POT_WIDTH] in — membrane BRAM read port, 1-cycle latency, read-first.
- `mem_waddr`[MEM_AW], `mem_wren`, `mem_wdata`[POT_WIDTH] out — membrane BRAM write port.

## Operation
- Membrane address = oc·S + y·OUT_WIDTH + x.
- Weight address = oc·(IN_CHANNELS·K²+1) + kidx.
- Bias address = oc·(IN_CHANNELS·K²+1) + IN_CHANNELS·K².
- States: IDLE, ACT_BIAS, ACT_SWEEP, ACT_DONE.
- `ev_ready` = (state==IDLE) && !`act_start`, so `act_start` wins a simultaneous event.
- Accumulate stage 0 (transfer cycle): issue `mem_ren` and `w_ren` for the event.
- Accumulate stage 1: sum = sat(pot + sext(w)), then write.
  - If the stage-1 address equals the previous cycle's write address, pot is taken from the forwarded value instead of `mem_rdata`.
- A transferred event is dropped with no read or write if `ev_skip` = 1, or if `ev_y`/`ev_x` ≥ OUT_WIDTH.
- IDLE→ACT_BIAS on `act_start`. A pending stage-1 write still completes.
- ACT_BIAS (1 cycle per channel): read the channel bias, then go to ACT_SWEEP.
- ACT_SWEEP: read neurons 0..S−1 of the channel, one per cycle. One cycle later for each neuron:
  - u = leak(sat(v + sext(bias))).
  - spk = (u ≥ THRESHOLD).
  - Write back sat(u − THRESHOLD) if spiking, else u.
  - Write back 0 for every neuron when `last_time_step` was latched.
- After the last channel's sweep go to ACT_DONE, pulse `act_done`, return to IDLE.
- Saturation clamps to [−2^(POT_WIDTH−1), 2^(POT_WIDTH−1)−1].
- `busy` = state≠IDLE, or stage 1 valid.
- Reset mid-activation: state returns to IDLE, pending write is cancelled, no `act_done`; BRAM contents are unspecified.

## Timing
- All outputs reset to 0.
- Events: sustained throughput of 1 per cycle; write occurs 1 cycle after transfer.
- With `act_start` sampled at cycle 0:
  - Bias for channel c is fetched at cycle 1 + c·(S+1).
  - Neuron n of channel c is read at cycle 2 + c·(S+1) + n; its `spk_valid`/write occur one cycle later.
  - `act_done` pulses at cycle EC_SIZE·(S+1) + 2.
- `spk_addr` equals the written membrane address.

## Configuration
- `CONV_LIF_LEAK_EN` defined: leak applied as above (LIF neuron).
- Macro undefined: u = sat(v + bias), no leak (IF neuron); `BETA_SHIFT` is ignored.

## Structure
- Package `conv_lif_pkg`:
  - state enum;
  - `sat_add` function;
  - address-computation functions;
  - pipeline-stage struct {valid, addr, w}.
- Sub-module `lif_update`: combinational bias-add/leak/threshold/reset datapath, shared by nothing else, instantiated once.

## Test plan
Common parameters: OUT_WIDTH=4, EC_SIZE=2, IC=1, K=3, THRESHOLD=256, BETA_SHIFT=3, zeroed BRAM.

- Three back-to-back events to (oc0, 1, 2), weight 100 → address 6 reads 300 (forwarding exercised).
- Events with pot = 32700 and w = 100 → pot saturates at 32767; `ev_skip` event → no `mem_wren`.
- Activation with pot = 300, bias 0:
  - leak on → u = 263, spike, write 7;
  - leak off → u = 300, write 44.
- `act_start` together with `ev_valid` → `ev_ready` = 0 that cycle; `act_done` at cycle 36; 32 `spk_valid` pulses.
- `last_time_step` = 1 → all 32 writes are 0; spikes still reported.
- `rst` at cycle 10 of activation → IDLE next cycle, no `act_done`, `ev_ready` = 1.

Source files
------------

// File: rtl/conv_lif_pkg.sv
// Shared types and fixed-point helpers for the convolutional LIF neuron core.
// Define CONV_LIF_LEAK_EN to build leaky (LIF) neurons; left undefined the core builds plain IF neurons.
package conv_lif_pkg;

`ifdef CONV_LIF_LEAK_EN
    localparam bit LEAK_EN = 1'b1;
`else
    localparam bit LEAK_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACT_BIAS  = 2'd1,
        ACT_SWEEP = 2'd2,
        ACT_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic valid;
        int   addr;
        int   w;
    } stage_t;

    // Signed add clamped to a width-bit two's-complement range.
    function automatic int sat_add(input int a, input int b, input int width);
        longint s;
        longint hi;
        longint lo;
        s  = longint'(a) + longint'(b);
        hi = (longint'(1) <<< (width - 1)) - 1;
        lo = -(longint'(1) <<< (width - 1));
        if (s > hi) return int'(hi);
        if (s < lo) return int'(lo);
        return int'(s);
    endfunction

    function automatic int mem_addr(input int oc, input int y, input int x, input int side);
        return oc * side * side + y * side + x;
    endfunction

    function automatic int w_addr(input int oc, input int kidx, input int nk);
        return oc * (nk + 1) + kidx;
    endfunction

    function automatic int bias_addr(input int oc, input int nk);
        return oc * (nk + 1) + nk;
    endfunction

endpackage

// File: rtl/conv_lif_core_lif_update.sv
// Combinational neuron update: bias add, optional leak (CONV_LIF_LEAK_EN), threshold and reset.
module lif_update
    import conv_lif_pkg::*;
#(
    parameter int POT_WIDTH  = 16,
    parameter int W_WIDTH    = 8,
    parameter int THRESHOLD  = 256,
    parameter int BETA_SHIFT = 3
) (
    input  logic [POT_WIDTH-1:0] i_v,
    input  logic [W_WIDTH-1:0]   i_bias,
    input  logic                 i_last,
    output logic                 o_spk,
    output logic [POT_WIDTH-1:0] o_wdata
);

    int w_b;
    int w_u;
    int w_r;

    // The leak never grows the magnitude, so only the bias add and the threshold subtract can overflow.
    always_comb begin
        w_b     = sat_add(int'($signed(i_v)), int'($signed(i_bias)), POT_WIDTH);
        w_u     = LEAK_EN ? (w_b - (w_b >>> BETA_SHIFT)) : w_b;
        o_spk   = (w_u >= THRESHOLD);
        w_r     = o_spk ? sat_add(w_u, -THRESHOLD, POT_WIDTH) : w_u;
        o_wdata = i_last ? '0 : POT_WIDTH'(w_r);
    end

endmodule

// File: rtl/conv_lif_core.sv
// Event-driven convolutional LIF core: accumulates weighted events into membrane BRAM, then sweeps/fires on command.
// Leak is enabled by defining CONV_LIF_LEAK_EN.
module conv_lif_core
    import conv_lif_pkg::*;
#(
    parameter int IN_CHANNELS = 2,
    parameter int EC_SIZE     = 2,
    parameter int KERNEL_SIZE = 3,
    parameter int OUT_WIDTH   = 26,
    parameter int POT_WIDTH   = 16,
    parameter int W_WIDTH     = 8,
    parameter int THRESHOLD   = 256,
    parameter int BETA_SHIFT  = 3,
    parameter int MEM_AW      = $clog2(EC_SIZE * OUT_WIDTH * OUT_WIDTH),
    parameter int W_AW        = $clog2(EC_SIZE * (IN_CHANNELS * KERNEL_SIZE * KERNEL_SIZE + 1))
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic                                                   i_ev_valid,
    output logic                                                   o_ev_ready,
    input  logic [$clog2(OUT_WIDTH)-1:0]                           i_ev_y,
    input  logic [$clog2(OUT_WIDTH)-1:0]                           i_ev_x,
    input  logic [$clog2(EC_SIZE)-1:0]                             i_ev_oc,
    input  logic [$clog2(IN_CHANNELS*KERNEL_SIZE*KERNEL_SIZE)-1:0] i_ev_kidx,
    input  logic                                                   i_ev_skip,
    input  logic                                                   i_act_start,
    input  logic                                                   i_last_time_step,
    output logic                                                   o_busy,
    output logic                                                   o_act_done,
    output logic                                                   o_spk_valid,
    output logic                                                   o_spk,
    output logic [MEM_AW-1:0]                                      o_spk_addr,
    output logic [W_AW-1:0]                                        o_w_addr,
    output logic                                                   o_w_ren,
    input  logic [W_WIDTH-1:0]                                     i_w_rdata,
    output logic [MEM_AW-1:0]                                      o_mem_raddr,
    output logic                                                   o_mem_ren,
    input  logic [POT_WIDTH-1:0]                                   i_mem_rdata,
    output logic [MEM_AW-1:0]                                      o_mem_waddr,
    output logic                                                   o_mem_wren,
    output logic [POT_WIDTH-1:0]                                   o_mem_wdata
);

    localparam int S  = OUT_WIDTH * OUT_WIDTH;
    localparam int NK = IN_CHANNELS * KERNEL_SIZE * KERNEL_SIZE;

    state_t               r_state;
    state_t               w_next;
    int                   r_chan;
    int                   r_nidx;
    logic                 r_last;
    logic                 r_biasLoad;
    logic [W_WIDTH-1:0]   r_bias;
    logic                 r_evValid;
    logic [MEM_AW-1:0]    r_evAddr;
    logic                 r_swpValid;
    logic [MEM_AW-1:0]    r_swpAddr;
    logic                 r_actDone;
    stage_t               r_fwd;

    logic                 w_evAccept;
    logic [MEM_AW-1:0]    w_evAddr;
    logic [MEM_AW-1:0]    w_swpAddr;
    int                   w_evPot;
    logic [POT_WIDTH-1:0] w_evSum;
    logic                 w_lifSpk;
    logic [POT_WIDTH-1:0] w_lifData;
    logic [MEM_AW-1:0]    w_wrAddr;
    logic [POT_WIDTH-1:0] w_wrData;

    // act_start blocks the event port in the same cycle so activation always wins.
    assign o_ev_ready = !rst && (r_state == IDLE) && !i_act_start;
    assign w_evAccept = i_ev_valid && o_ev_ready && !i_ev_skip
                        && (int'(i_ev_y) < OUT_WIDTH) && (int'(i_ev_x) < OUT_WIDTH);
    assign w_evAddr   = MEM_AW'(mem_addr(int'(i_ev_oc), int'(i_ev_y), int'(i_ev_x), OUT_WIDTH));
    assign w_swpAddr  = MEM_AW'(r_chan * S + r_nidx);
    assign o_busy     = !rst && ((r_state != IDLE) || r_evValid);
    assign o_act_done = r_actDone;
    assign o_mem_waddr = w_wrAddr;
    assign o_mem_wdata = w_wrData;
    assign o_spk_addr  = w_wrAddr;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (i_act_start) w_next = ACT_BIAS;
            ACT_BIAS:  w_next = ACT_SWEEP;
            ACT_SWEEP: if (r_nidx == S - 1) w_next = (r_chan == EC_SIZE - 1) ? ACT_DONE : ACT_BIAS;
            ACT_DONE:  w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_comb begin
        o_mem_ren   = 1'b0;
        o_mem_raddr = '0;
        o_w_ren     = 1'b0;
        o_w_addr    = '0;
        if (w_evAccept) begin
            o_mem_ren   = 1'b1;
            o_mem_raddr = w_evAddr;
            o_w_ren     = 1'b1;
            o_w_addr    = W_AW'(w_addr(int'(i_ev_oc), int'(i_ev_kidx), NK));
        end else if (!rst && r_state == ACT_BIAS) begin
            o_w_ren  = 1'b1;
            o_w_addr = W_AW'(bias_addr(r_chan, NK));
        end else if (!rst && r_state == ACT_SWEEP) begin
            o_mem_ren   = 1'b1;
            o_mem_raddr = w_swpAddr;
        end
    end

    // The BRAM is read-first, so a write landing one cycle earlier is invisible to the read; forward it.
    always_comb begin
        w_evPot     = (r_fwd.valid && r_fwd.addr == int'(r_evAddr)) ? r_fwd.w : int'($signed(i_mem_rdata));
        w_evSum     = POT_WIDTH'(sat_add(w_evPot, int'($signed(i_w_rdata)), POT_WIDTH));
        o_mem_wren  = 1'b0;
        o_spk_valid = 1'b0;
        o_spk       = 1'b0;
        w_wrAddr    = '0;
        w_wrData    = '0;
        if (!rst && r_evValid) begin
            o_mem_wren = 1'b1;
            w_wrAddr   = r_evAddr;
            w_wrData   = w_evSum;
        end else if (!rst && r_swpValid) begin
            o_mem_wren  = 1'b1;
            o_spk_valid = 1'b1;
            o_spk       = w_lifSpk;
            w_wrAddr    = r_swpAddr;
            w_wrData    = w_lifData;
        end
    end

    lif_update #(
        .POT_WIDTH  (POT_WIDTH),
        .W_WIDTH    (W_WIDTH),
        .THRESHOLD  (THRESHOLD),
        .BETA_SHIFT (BETA_SHIFT)
    ) u_lif (
        .i_v     (i_mem_rdata),
        .i_bias  (r_bias),
        .i_last  (r_last),
        .o_spk   (w_lifSpk),
        .o_wdata (w_lifData)
    );

    // Bias arrives from the ROM the cycle after ACT_BIAS, just before the channel's first neuron data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_chan     <= 0;
            r_nidx     <= 0;
            r_last     <= 1'b0;
            r_biasLoad <= 1'b0;
            r_bias     <= '0;
            r_evValid  <= 1'b0;
            r_evAddr   <= '0;
            r_swpValid <= 1'b0;
            r_swpAddr  <= '0;
            r_actDone  <= 1'b0;
            r_fwd      <= '0;
        end else begin
            r_state    <= w_next;
            r_actDone  <= (r_state == ACT_DONE);
            r_biasLoad <= (r_state == ACT_BIAS);
            if (r_biasLoad) r_bias <= i_w_rdata;
            r_evValid  <= w_evAccept;
            r_evAddr   <= w_evAddr;
            r_swpValid <= (r_state == ACT_SWEEP);
            r_swpAddr  <= w_swpAddr;
            r_fwd.valid <= o_mem_wren;
            r_fwd.addr  <= int'(w_wrAddr);
            r_fwd.w     <= int'($signed(w_wrData));
            if (r_state == IDLE && i_act_start) begin
                r_last <= i_last_time_step;
                r_chan <= 0;
                r_nidx <= 0;
            end else if (r_state == ACT_SWEEP) begin
                if (r_nidx == S - 1) begin
                    r_nidx <= 0;
                    r_chan <= r_chan + 1;
                end else begin
                    r_nidx <= r_nidx + 1;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_lif_core.sv
// Scoreboard bench for conv_lif_core (OUT_WIDTH=4, EC_SIZE=2, IC=1, K=3); expectations follow CONV_LIF_LEAK_EN.
module tb_conv_lif_core;

    logic        clk;
    logic        rst;
    logic        ev_valid;
    logic        ev_ready;
    logic [1:0]  ev_y;
    logic [1:0]  ev_x;
    logic [0:0]  ev_oc;
    logic [3:0]  ev_kidx;
    logic        ev_skip;
    logic        act_start;
    logic        last_time_step;
    logic        busy;
    logic        act_done;
    logic        spk_valid;
    logic        spk;
    logic [4:0]  spk_addr;
    logic [4:0]  w_addr;
    logic        w_ren;
    logic [7:0]  w_rdata;
    logic [4:0]  mem_raddr;
    logic        mem_ren;
    logic [15:0] mem_rdata;
    logic [4:0]  mem_waddr;
    logic        mem_wren;
    logic [15:0] mem_wdata;

    logic [15:0] memArr [0:31];
    logic [15:0] preArr [0:31];
    logic        preloadEn;
    logic [7:0]  wrom [0:19];

    typedef struct {
        int addr;
        int data;
        bit sweep;
        bit spk;
    } exp_t;

    exp_t expQ[$];
    int   testsRun  = 0;
    int   failCount = 0;
    int   wrCount   = 0;
    int   spkCount  = 0;
    int   spkOnes   = 0;

    conv_lif_core #(
        .IN_CHANNELS (1),
        .EC_SIZE     (2),
        .KERNEL_SIZE (3),
        .OUT_WIDTH   (4),
        .POT_WIDTH   (16),
        .W_WIDTH     (8),
        .THRESHOLD   (256),
        .BETA_SHIFT  (3),
        .MEM_AW      (5),
        .W_AW        (5)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_ev_valid       (ev_valid),
        .o_ev_ready       (ev_ready),
        .i_ev_y           (ev_y),
        .i_ev_x           (ev_x),
        .i_ev_oc          (ev_oc),
        .i_ev_kidx        (ev_kidx),
        .i_ev_skip        (ev_skip),
        .i_act_start      (act_start),
        .i_last_time_step (last_time_step),
        .o_busy           (busy),
        .o_act_done       (act_done),
        .o_spk_valid      (spk_valid),
        .o_spk            (spk),
        .o_spk_addr       (spk_addr),
        .o_w_addr         (w_addr),
        .o_w_ren          (w_ren),
        .i_w_rdata        (w_rdata),
        .o_mem_raddr      (mem_raddr),
        .o_mem_ren        (mem_ren),
        .i_mem_rdata      (mem_rdata),
        .o_mem_waddr      (mem_waddr),
        .o_mem_wren       (mem_wren),
        .o_mem_wdata      (mem_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first membrane BRAM and weight ROM, both with one-cycle read latency.
    always @(posedge clk) begin
        if (preloadEn) begin
            for (int i = 0; i < 32; i++) memArr[i] <= preArr[i];
        end else begin
            if (mem_ren) mem_rdata <= memArr[mem_raddr];
            if (mem_wren) memArr[mem_waddr] <= mem_wdata;
        end
        if (w_ren) w_rdata <= wrom[w_addr];
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input int oc, input int y, input int x,
                                 input int k, input logic skip);
        ev_valid = v;
        ev_oc    = 1'(oc);
        ev_y     = 2'(y);
        ev_x     = 2'(x);
        ev_kidx  = 4'(k);
        ev_skip  = skip;
    endtask

    task automatic pushWrite(input int a, input int d);
        exp_t e;
        e.addr = a; e.data = d; e.sweep = 1'b0; e.spk = 1'b0;
        expQ.push_back(e);
    endtask

    // Hand-computed sweep results for the activation preload: mem[6]=300, mem[19]=250, mem[20]=32767,
    // channel 0 bias 0, channel 1 bias 5.
    task automatic expNeuron(input int a, output int d, output bit s);
`ifdef CONV_LIF_LEAK_EN
        if (a == 6)       begin d = 7;     s = 1'b1; end
        else if (a == 19) begin d = 224;   s = 1'b0; end
        else if (a == 20) begin d = 28416; s = 1'b1; end
`else
        if (a == 6)       begin d = 44;    s = 1'b1; end
        else if (a == 19) begin d = 255;   s = 1'b0; end
        else if (a == 20) begin d = 32511; s = 1'b1; end
`endif
        else if (a < 16)  begin d = 0;     s = 1'b0; end
        else              begin d = 5;     s = 1'b0; end
    endtask

    task automatic pushSweep(input int first, input int last, input bit zeroed);
        exp_t e;
        int   d;
        bit   s;
        for (int a = first; a <= last; a++) begin
            expNeuron(a, d, s);
            e.addr = a; e.data = zeroed ? 0 : d; e.sweep = 1'b1; e.spk = s;
            expQ.push_back(e);
        end
    endtask

    task automatic preload;
        for (int i = 0; i < 32; i++) preArr[i] = 16'd0;
        preArr[6]  = 16'd300;
        preArr[19] = 16'd250;
        preArr[20] = 16'd32767;
        preloadEn = 1'b1;
        tick;
        preloadEn = 1'b0;
    endtask

    // Monitor: every membrane write pops one expectation; spikes must coincide with sweep writes.
    always @(negedge clk) begin
        exp_t e;
        if (mem_wren === 1'b1) begin
            wrCount++;
            if (spk_valid === 1'b1) begin
                spkCount++;
                if (spk === 1'b1) spkOnes++;
            end
            if (expQ.size() == 0) begin
                testsRun++;
                failCount++;
                $display("[TB] FAIL unexpected_write: got addr %0d data %0d, expected no write",
                         mem_waddr, $signed(mem_wdata));
            end else begin
                e = expQ.pop_front();
                checkOutput("wr_addr", int'(mem_waddr), e.addr);
                checkOutput("wr_data", int'($signed(mem_wdata)), e.data);
                checkOutput("spk_valid", int'(spk_valid), int'(e.sweep));
                if (e.sweep) begin
                    checkOutput("spk", int'(spk), int'(e.spk));
                    checkOutput("spk_addr", int'(spk_addr), e.addr);
                end
            end
        end else if (spk_valid === 1'b1) begin
            testsRun++;
            failCount++;
            $display("[TB] FAIL spurious_spike: got spk_valid 1 at addr %0d, expected 0", spk_addr);
        end
    end

    initial begin
        int wrBefore;
        int spkBefore;
        int onesBefore;
        int doneCycle;
        int doneCount;

        rst = 1'b1;
        preloadEn = 1'b0;
        act_start = 1'b0;
        last_time_step = 1'b0;
        applyStimulus(1'b0, 0, 0, 0, 0, 1'b0);
        for (int i = 0; i < 20; i++) wrom[i] = 8'd0;
        wrom[4]  = 8'd100;
        wrom[10] = 8'd100;
        wrom[11] = 8'h9C;
        wrom[9]  = 8'd0;
        wrom[19] = 8'd5;
        for (int i = 0; i < 32; i++) preArr[i] = 16'd0;
        preloadEn = 1'b1;
        repeat (3) tick;
        preloadEn = 1'b0;
        rst = 1'b0;
        #1;
        checkOutput("reset_ev_ready", int'(ev_ready), 1);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_act_done", int'(act_done), 0);
        checkOutput("reset_spk_valid", int'(spk_valid), 0);

        // Three back-to-back events to the same neuron exercise write forwarding.
        pushWrite(6, 100);
        pushWrite(6, 200);
        pushWrite(6, 300);
        applyStimulus(1'b1, 0, 1, 2, 4, 1'b0);
        repeat (3) tick;
        applyStimulus(1'b0, 0, 0, 0, 0, 1'b0);
        repeat (3) tick;

        // Saturation at both rails, the second positive event via the forwarded value.
        for (int i = 0; i < 32; i++) preArr[i] = 16'd0;
        preArr[16] = 16'd32700;
        preArr[17] = 16'(-32700);
        preloadEn = 1'b1;
        tick;
        preloadEn = 1'b0;
        pushWrite(16, 32767);
        pushWrite(16, 32767);
        pushWrite(17, -32768);
        applyStimulus(1'b1, 1, 0, 0, 0, 1'b0);
        tick;
        tick;
        applyStimulus(1'b1, 1, 0, 1, 1, 1'b0);
        tick;
        applyStimulus(1'b0, 0, 0, 0, 0, 1'b0);
        repeat (3) tick;

        wrBefore = wrCount;
        applyStimulus(1'b1, 0, 1, 2, 4, 1'b1);
        tick;
        applyStimulus(1'b0, 0, 0, 0, 0, 1'b0);
        repeat (3) tick;
        checkOutput("skip_no_write", wrCount - wrBefore, 0);

        // Activation, with a competing event in the act_start cycle.
        preload();
        pushSweep(0, 31, 1'b0);
        spkBefore = spkCount;
        onesBefore = spkOnes;
        applyStimulus(1'b1, 0, 0, 0, 4, 1'b0);
        act_start = 1'b1;
        last_time_step = 1'b0;
        #1;
        checkOutput("ev_ready_vs_act_start", int'(ev_ready), 0);
        tick;
        applyStimulus(1'b0, 0, 0, 0, 0, 1'b0);
        act_start = 1'b0;
        doneCycle = -1;
        doneCount = 0;
        for (int cyc = 1; cyc < 60; cyc++) begin
            if (act_done === 1'b1) begin
                doneCount++;
                if (doneCycle < 0) doneCycle = cyc;
            end
            tick;
        end
        checkOutput("act_done_cycle", doneCycle, 36);
        checkOutput("act_done_pulses", doneCount, 1);
        checkOutput("spk_valid_count", spkCount - spkBefore, 32);
        checkOutput("spike_count", spkOnes - onesBefore, 2);
        checkOutput("idle_after_act", int'(busy), 0);

        // Last time step: every neuron is cleared but spikes are still reported.
        preload();
        pushSweep(0, 31, 1'b1);
        spkBefore = spkCount;
        onesBefore = spkOnes;
        act_start = 1'b1;
        last_time_step = 1'b1;
        tick;
        act_start = 1'b0;
        last_time_step = 1'b0;
        doneCount = 0;
        for (int cyc = 1; cyc < 60; cyc++) begin
            if (act_done === 1'b1) doneCount++;
            tick;
        end
        checkOutput("last_act_done_pulses", doneCount, 1);
        checkOutput("last_spk_valid_count", spkCount - spkBefore, 32);
        checkOutput("last_spike_count", spkOnes - onesBefore, 2);

        // Reset in cycle 10 of an activation: neurons 0..6 were written, nothing afterwards.
        preload();
        pushSweep(0, 6, 1'b0);
        act_start = 1'b1;
        tick;
        act_start = 1'b0;
        repeat (9) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        checkOutput("rst_mid_ev_ready", int'(ev_ready), 1);
        checkOutput("rst_mid_busy", int'(busy), 0);
        doneCount = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (act_done === 1'b1) doneCount++;
            tick;
        end
        checkOutput("rst_mid_no_act_done", doneCount, 0);
        checkOutput("scoreboard_drained", expQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
